// File: rtl/vend_fsm_gen_if.sv
// Vending controller bus: coin/command inputs and display/eject outputs.
// The slave modport faces the controller, the master modport faces the command decoders.
interface vend_fsm_gen_if #(
  parameter int BAL_W  = 9,
  parameter int ITEM_W = 3
);
  logic              coin_a, coin_b, confirm, cancel;
  logic [ITEM_W-1:0] item_sel;
  logic [2:0]        state;
  logic [BAL_W-1:0]  credit, price;
  logic              change_a, change_b, coin_reject, change_short;
  logic              color_flag, seven_seg_enb;

  modport slave (
    input  coin_a, coin_b, confirm, cancel, item_sel,
    output state, credit, price, change_a, change_b, coin_reject,
           change_short, color_flag, seven_seg_enb
  );

  modport master (
    output coin_a, coin_b, confirm, cancel, item_sel,
    input  state, credit, price, change_a, change_b, coin_reject,
           change_short, color_flag, seven_seg_enb
  );
endinterface

// File: rtl/vend_fsm_gen.sv
// Credit-accumulating vending controller with price table, two coin types, refund and coin-pulse change.
// Define VEND_TIMEOUT_EN to add a PAY inactivity timeout that behaves like cancel.
module vend_fsm_gen #(
  parameter int BAL_W  = 9,
  parameter int ITEM_W = 3,
  parameter logic [(2**ITEM_W)*BAL_W-1:0] PRICE_TABLE =
    {9'd225, 9'd200, 9'd175, 9'd150, 9'd125, 9'd100, 9'd75, 9'd50},
  parameter int COIN_A = 25,
  parameter int COIN_B = 10,
  parameter int unsigned DELAY_CYCLES = 500000000,
  parameter int unsigned GAP_CYCLES   = 50000000,
  parameter longint unsigned TIMEOUT_CYCLES = 64'd3000000000
) (
  input  logic           clk,
  input  logic           reset,
  vend_fsm_gen_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0, LOAD = 3'd1, PAY = 3'd2, DISPENSE = 3'd3, CHANGE = 3'd4, DONE = 3'd5
  } state_t;

  localparam int unsigned CNT_MAX = (DELAY_CYCLES > GAP_CYCLES) ? DELAY_CYCLES : GAP_CYCLES;
  localparam int CNT_W = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  state_t             state_q, state_d;
  logic [BAL_W-1:0]   credit_q, credit_d, price_q, price_d, rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ca_q, ca_d, cb_q, cb_d, rej_q, rej_d, short_q, short_d;
  logic [BAL_W:0]     sum_a, sum_b;
  logic               tmo;

  // One extra bit catches overflow of the credit register.
  assign sum_a = {1'b0, credit_q} + (BAL_W+1)'(COIN_A);
  assign sum_b = {1'b0, credit_q} + (BAL_W+1)'(COIN_B);

`ifdef VEND_TIMEOUT_EN
  localparam int TCNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [TCNT_W-1:0] tcnt_q;

  // Credit only moves in PAY on an accepted coin, so a change restarts the idle window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                      tcnt_q <= '0;
    else if (state_q != PAY || credit_d != credit_q) tcnt_q <= '0;
    else if (!tmo)                                   tcnt_q <= tcnt_q + TCNT_W'(1);
  end

  assign tmo = (state_q == PAY) && (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      credit_q <= '0;
      price_q  <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      ca_q     <= 1'b0;
      cb_q     <= 1'b0;
      rej_q    <= 1'b0;
      short_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      price_q  <= price_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      ca_q     <= ca_d;
      cb_q     <= cb_d;
      rej_q    <= rej_d;
      short_q  <= short_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    price_d  = price_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    ca_d     = 1'b0;
    cb_d     = 1'b0;
    rej_d    = bus.coin_a | bus.coin_b;
    short_d  = short_q;
    case (state_q)
      IDLE: begin
        credit_d = '0;
        price_d  = BAL_W'(bus.item_sel);
        if (bus.confirm) begin
          state_d = LOAD;
          short_d = 1'b0;
        end
      end
      LOAD: begin
        price_d = PRICE_TABLE[bus.item_sel*BAL_W +: BAL_W];
        state_d = PAY;
      end
      PAY: begin
        rej_d = 1'b0;
        if (bus.cancel || tmo) begin
          rej_d   = bus.coin_a | bus.coin_b;
          rem_d   = credit_q;
          cnt_d   = '0;
          state_d = (tmo && credit_q == '0) ? DONE : CHANGE;
        end else begin
          if (bus.coin_a) begin
            if (!sum_a[BAL_W]) credit_d = sum_a[BAL_W-1:0];
            else               rej_d    = 1'b1;
            if (bus.coin_b)    rej_d    = 1'b1;
          end else if (bus.coin_b) begin
            if (!sum_b[BAL_W]) credit_d = sum_b[BAL_W-1:0];
            else               rej_d    = 1'b1;
          end
          // Compares the registered credit, so the paying coin lands one cycle earlier.
          if (credit_q >= price_q) begin
            state_d = DISPENSE;
            cnt_d   = CNT_W'(DELAY_CYCLES - 1);
          end
        end
      end
      DISPENSE: begin
        if (cnt_q == '0) begin
          state_d = CHANGE;
          rem_d   = credit_q - price_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CHANGE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rem_q >= BAL_W'(COIN_A)) begin
          ca_d  = 1'b1;
          rem_d = rem_q - BAL_W'(COIN_A);
          cnt_d = CNT_W'(GAP_CYCLES);
        end else if (rem_q >= BAL_W'(COIN_B)) begin
          cb_d  = 1'b1;
          rem_d = rem_q - BAL_W'(COIN_B);
          cnt_d = CNT_W'(GAP_CYCLES);
        end else begin
          state_d = DONE;
          short_d = (rem_q != '0);
        end
      end
      DONE: begin
        credit_d = '0;
        price_d  = '0;
        rem_d    = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.state         = state_q;
  assign bus.credit        = credit_q;
  assign bus.price         = price_q;
  assign bus.change_a      = ca_q;
  assign bus.change_b      = cb_q;
  assign bus.coin_reject   = rej_q;
  assign bus.change_short  = short_q;
  assign bus.color_flag    = (state_q == DISPENSE);
  assign bus.seven_seg_enb = (state_q != DISPENSE);

endmodule

// File: tb/tb_vend_fsm_gen.sv
// Scoreboard bench for vend_fsm_gen: stimulus queues expected events, a monitor pops and compares them.
module tb_vend_fsm_gen;
  localparam int BAL_W = 9, ITEM_W = 3;
  localparam int EV_REJ = 1, EV_DISP = 2, EV_DEND = 3, EV_CA = 4, EV_CB = 5, EV_DONE = 6;

  typedef struct { int kind; int data; } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0, n_fail = 0, cyc = 0, last_coin = 0;
  ev_t  expq[$];

  vend_fsm_gen_if #(.BAL_W(BAL_W), .ITEM_W(ITEM_W)) vif();

  vend_fsm_gen #(
    .BAL_W(BAL_W), .ITEM_W(ITEM_W), .COIN_A(25), .COIN_B(10),
    .DELAY_CYCLES(8), .GAP_CYCLES(2), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .reset(reset), .bus(vif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int k, input int d);
    ev_t e;
    e.kind = k;
    e.data = d;
    expq.push_back(e);
  endtask

  task automatic see(input int kind, input int data);
    ev_t e;
    if (expq.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected event: got kind %0d data %0d, want none (cyc %0d)", kind, data, cyc);
    end else begin
      e = expq.pop_front();
      chk("event kind", kind, e.kind);
      chk($sformatf("event %0d data", e.kind), data, e.data);
    end
  endtask

  // DISP data = credit*16 + cycles since last coin; pulse/DONE data = cycles since previous reference.
  task automatic monitor();
    int prev_st, st, dcnt, last_ref;
    prev_st = 0; dcnt = 0; last_ref = 0;
    forever begin
      @(negedge clk);
      st = int'(vif.state);
      if (!reset) begin
        prev_st = 0;
        dcnt    = 0;
      end else begin
        if (vif.coin_reject) see(EV_REJ, int'(vif.credit));
        if (prev_st == 3 && st != 3) begin
          see(EV_DEND, dcnt);
          dcnt = 0;
        end
        if (st == 3) begin
          if (prev_st != 3) see(EV_DISP, int'(vif.credit) * 16 + (cyc - last_coin));
          if (vif.color_flag && !vif.seven_seg_enb) dcnt++;
        end
        if (st == 4 && prev_st != 4) last_ref = cyc;
        if (vif.change_a) begin see(EV_CA, cyc - last_ref); last_ref = cyc; end
        if (vif.change_b) begin see(EV_CB, cyc - last_ref); last_ref = cyc; end
        if (st == 5 && prev_st != 5) see(EV_DONE, int'(vif.change_short) * 100 + (cyc - last_ref));
        prev_st = st;
      end
    end
  endtask

  task automatic pulse(input bit a, input bit b, input bit conf, input bit canc);
    vif.coin_a = a; vif.coin_b = b; vif.confirm = conf; vif.cancel = canc;
    if (a || b) last_coin = cyc;
    @(posedge clk); #1;
    vif.coin_a = 1'b0; vif.coin_b = 1'b0; vif.confirm = 1'b0; vif.cancel = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start(input int item);
    vif.item_sel = ITEM_W'(item);
    pulse(0, 0, 1, 0);
    idle(1);
  endtask

  initial begin
    vif.coin_a = 1'b0; vif.coin_b = 1'b0; vif.confirm = 1'b0; vif.cancel = 1'b0;
    vif.item_sel = '0;
    fork monitor(); join_none
    #2 reset = 1'b0;
    idle(3);
    chk("rst state", int'(vif.state), 0);
    chk("rst credit", int'(vif.credit), 0);
    chk("rst price", int'(vif.price), 0);
    chk("rst change_a", int'(vif.change_a), 0);
    chk("rst change_b", int'(vif.change_b), 0);
    chk("rst coin_reject", int'(vif.coin_reject), 0);
    chk("rst change_short", int'(vif.change_short), 0);
    chk("rst color_flag", int'(vif.color_flag), 0);
    chk("rst seven_seg_enb", int'(vif.seven_seg_enb), 1);
    reset = 1'b1;
    vif.item_sel = 3'd5;
    idle(2);
    chk("idle price shows sel", int'(vif.price), 5);

    // Exact payment, item 0 = 50
    expect_ev(EV_DISP, 50 * 16 + 2);
    expect_ev(EV_DEND, 8);
    expect_ev(EV_DONE, 1);
    start(0);
    chk("state PAY after confirm", int'(vif.state), 2);
    chk("load price item0", int'(vif.price), 50);
    pulse(1, 0, 0, 0);
    pulse(1, 0, 0, 0);
    idle(20);
    chk("exact back to IDLE", int'(vif.state), 0);
    chk("exact credit cleared", int'(vif.credit), 0);

    // Change with shortfall: 65 paid for 50
    expect_ev(EV_DISP, 65 * 16 + 2);
    expect_ev(EV_DEND, 8);
    expect_ev(EV_CB, 1);
    expect_ev(EV_DONE, 100 + 3);
    start(0);
    repeat (4) pulse(0, 1, 0, 0);
    pulse(1, 0, 0, 0);
    idle(25);
    chk("short holds in IDLE", int'(vif.change_short), 1);

    // Cancel/refund of 45 on item 3
    expect_ev(EV_CA, 1);
    expect_ev(EV_CB, 3);
    expect_ev(EV_CB, 3);
    expect_ev(EV_DONE, 3);
    start(3);
    chk("short cleared by confirm", int'(vif.change_short), 0);
    chk("load price item3", int'(vif.price), 125);
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    pulse(0, 1, 0, 0);
    pulse(0, 0, 0, 1);
    idle(20);
    chk("refund back to IDLE", int'(vif.state), 0);

    // Coin in IDLE, simultaneous coins, coin during DISPENSE
    expect_ev(EV_REJ, 0);
    expect_ev(EV_REJ, 25);
    expect_ev(EV_DISP, 60 * 16 + 2);
    expect_ev(EV_REJ, 60);
    expect_ev(EV_DEND, 8);
    expect_ev(EV_CB, 1);
    expect_ev(EV_DONE, 3);
    pulse(1, 0, 0, 0);
    start(0);
    pulse(1, 1, 0, 0);
    pulse(0, 1, 0, 0);
    pulse(1, 0, 0, 0);
    idle(2);
    pulse(0, 1, 0, 0);
    idle(25);

    // Coin plus cancel: only the prior 10 is refunded
    expect_ev(EV_REJ, 10);
    expect_ev(EV_CB, 1);
    expect_ev(EV_DONE, 3);
    start(0);
    pulse(0, 1, 0, 0);
    pulse(1, 0, 0, 1);
    idle(15);

    // Reset between change pulses of a 75 refund
    expect_ev(EV_CA, 1);
    start(7);
    chk("load price item7", int'(vif.price), 225);
    repeat (3) pulse(1, 0, 0, 0);
    pulse(0, 0, 0, 1);
    idle(1);
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    chk("mid-change rst state", int'(vif.state), 0);
    chk("mid-change rst credit", int'(vif.credit), 0);
    idle(3);
    reset = 1'b1;
    idle(20);
    chk("post-reset state", int'(vif.state), 0);

    // Inactivity with 10 paid on item 1
    start(1);
`ifdef VEND_TIMEOUT_EN
    expect_ev(EV_CB, 1);
    expect_ev(EV_DONE, 3);
    pulse(0, 1, 0, 0);
    idle(40);
    chk("timeout back to IDLE", int'(vif.state), 0);
`else
    pulse(0, 1, 0, 0);
    idle(40);
    chk("no timeout stays PAY", int'(vif.state), 2);
    chk("no timeout credit", int'(vif.credit), 10);
    expect_ev(EV_CB, 1);
    expect_ev(EV_DONE, 3);
    pulse(0, 0, 0, 1);
    idle(15);
`endif

    chk("scoreboard drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/vend_fsm_gen.md
# vend_fsm_gen

Parametrised vending-machine controller, the next generation of the single-product vending FSM. It supports a configurable item price table, two configurable coin denominations and cancel/refund. It accumulates paid credit instead of counting down, and returns change as discrete coin-eject pulses. It sits between the debounced button/UART command decoders and the seven-segment/LED display logic.

## Interface
- `BAL_W`, 9: width of credit, price and change arithmetic.
- `ITEM_W`, 3: item select width; the table holds 2^ITEM_W entries.
- `PRICE_TABLE`, {2^ITEM_W x BAL_W}: packed prices, entry i at bits [i*BAL_W +: BAL_W]. Default entry i = 25*(i+2), giving 50, 75, …, 225.
- `COIN_A`, 25: value of coin A (quarter).
- `COIN_B`, 10: value of coin B (dime).
- `DELAY_CYCLES`, 500000000: length of the dispense hold.
- `GAP_CYCLES`, 50000000: idle cycles between change pulses.
- `TIMEOUT_CYCLES`, 3000000000: PAY inactivity limit, used only with `VEND_TIMEOUT_EN`.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `coin_a`, `coin_b`  in  1  single-cycle coin pulses (button OR UART, merged upstream).
- `confirm`  in  1  single-cycle pulse; latches the selected item.
- `cancel`  in  1  single-cycle pulse; aborts payment.
- `item_sel`  in  ITEM_W  item select switches.
- `state`  out  3  current state encoding.
- `credit`  out  BAL_W  money inserted so far.
- `price`  out  BAL_W  latched price of the selected item.
- `change_a`, `change_b`  out  1  one-cycle coin-eject pulses.
- `coin_reject`  out  1  one-cycle pulse when a coin is not accepted.
- `change_short`  out  1  level; remainder that cannot be returned is nonzero.
- `color_flag`, `seven_seg_enb`  out  1  display controls.

## Operation
States: IDLE=0, LOAD=1, PAY=2, DISPENSE=3, CHANGE=4, DONE=5. Codes 6 and 7 go to IDLE on the next clock.

- **IDLE:** `credit`=0 and `price`={0,item_sel}, so the display shows the selection. `confirm` → LOAD.
- **LOAD:** `price` ← PRICE_TABLE[item_sel]. Go to PAY unconditionally.
- **PAY, coin handling:**
  - `coin_a` adds COIN_A to `credit`; `coin_b` adds COIN_B.
  - If both are high in the same cycle, coin_a is accepted and coin_b is rejected.
  - If the sum would exceed 2^BAL_W−1, the coin is rejected and `credit` is unchanged.
- **PAY, exits:**
  - When the registered `credit` ≥ `price`, go to DISPENSE. The check uses the value after the accepting edge, so it takes effect the next cycle.
  - `cancel` → CHANGE with the refund flag set. `cancel` wins over a coin in the same cycle, and that coin is rejected.
- **DISPENSE:** hold for DELAY_CYCLES, then go to CHANGE with remainder = `credit` − `price`.
- **CHANGE (remainder register `rem`):**
  - While `rem` ≥ COIN_A: pulse `change_a`, subtract COIN_A, wait GAP_CYCLES.
  - Then, while `rem` ≥ COIN_B: pulse `change_b`, subtract COIN_B, wait GAP_CYCLES.
  - When `rem` < COIN_B, go to DONE. `change_short`=(rem≠0).
  - On refund, `rem` = `credit` instead.
- **DONE:** one cycle. Clears `credit` and `price`, goes to IDLE. `change_short` holds until the next `confirm`.
- **Coins outside PAY:** rejected with a `coin_reject` pulse.
- **Ignored inputs:** `confirm` outside IDLE and `cancel` outside PAY.
- **Outputs by state:**
  - `color_flag`=1 only in DISPENSE.
  - `seven_seg_enb`=0 only in DISPENSE.

## Timing
- **Reset values:** `state`=IDLE. Zero for `credit`, `price`, `change_a`, `change_b`, `coin_reject`, `change_short` and `color_flag`. `seven_seg_enb`=1.
- **Reset mid-operation:** returns to IDLE immediately, and all counters clear. Pending change is discarded and not ejected.
- **Registered outputs:** all outputs except `color_flag` and `seven_seg_enb` are registered. Those two decode `state`.
- **Input to state:** `confirm` → LOAD on the next edge, PAY one edge later.
- **Last coin to DISPENSE:** 2 cycles (coin edge, then compare edge).
- **Change pulse spacing:** first pulse 1 cycle after entering CHANGE. Successive pulses exactly GAP_CYCLES+1 cycles apart.
- **Last pulse to DONE:** GAP_CYCLES+1 cycles.
- **Counters:** the delay/gap counter is sized by `$clog2` of the largest count and reloads on every state entry.

## Configuration
- `VEND_TIMEOUT_EN` defined:
  - An inactivity counter runs in PAY and reloads on each accepted coin.
  - Reaching TIMEOUT_CYCLES acts as `cancel`: refund credit, no dispense.
  - If credit is 0 at timeout, the path goes straight to DONE.
- `VEND_TIMEOUT_EN` undefined: PAY waits indefinitely, and no timeout counter is synthesised.

## Test plan
Bench parameters: DELAY_CYCLES=8, GAP_CYCLES=2, TIMEOUT_CYCLES=20.

- **Exact payment:** item_sel=0 (price 50), confirm, coin_a ×2 → DISPENSE 2 cycles after the 2nd coin, color_flag high for 8 cycles, no change pulses, change_short=0, back to IDLE.
- **Change with shortfall:** item 0, coin_b ×4 then coin_a (credit 65) → after dispense, one change_b pulse, no change_a, change_short=1.
- **Cancel/refund:** item 3 (125), coin_a, coin_b, coin_b, cancel → no DISPENSE, one change_a then two change_b pulses 3 cycles apart, change_short=0.
- **Simultaneous and late coins:** coin_a+coin_b in the same cycle in PAY → credit +25, coin_reject=1. Coin during DISPENSE → coin_reject, credit unchanged. Coin plus cancel in the same cycle → refund of prior credit only.
- **Reset mid-CHANGE:** assert reset low between change pulses → state=IDLE and credit=0 asynchronously, with no further change pulses.
- **Timeout (macro defined):** item 1, one coin_b, then idle 20 cycles → one change_b pulse, returns to IDLE. With the macro undefined, the same stimulus stays in PAY.
